// File: rtl/silife_max7219_pkg.sv
// rtl/silife_max7219_pkg.sv - MAX7219 register map, init words, FSM states and word helpers
package silife_max7219_pkg;

  localparam logic [3:0] REG_DIGIT0    = 4'd1;
  localparam logic [3:0] REG_DECODE    = 4'd9;
  localparam logic [3:0] REG_INTENSITY = 4'd10;
  localparam logic [3:0] REG_SCANLIMIT = 4'd11;
  localparam logic [3:0] REG_SHUTDOWN  = 4'd12;
  localparam logic [3:0] REG_TEST      = 4'd15;

  localparam logic [15:0] INIT_SHUTDOWN  = {4'h0, REG_SHUTDOWN,  8'h01};
  localparam logic [15:0] INIT_DECODE    = {4'h0, REG_DECODE,    8'h00};
  localparam logic [15:0] INIT_SCANLIMIT = {4'h0, REG_SCANLIMIT, 8'h07};
  localparam logic [15:0] INIT_TEST      = {4'h0, REG_TEST,      8'h00};

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FETCH,
    SAMPLE,
    SHIFT,
    LATCH
  } state_t;

  typedef enum logic [1:0] {
    GRP_INIT,
    GRP_BRIGHT,
    GRP_DIGIT
  } group_t;

  function automatic logic [15:0] make_word(input logic [3:0] addr, input logic [7:0] data);
    return {4'h0, addr, data};
  endfunction

  function automatic logic [7:0] bit_reverse(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

endpackage

// File: rtl/silife_max7219_chain_if.sv
// rtl/silife_max7219_chain_if.sv - grid read port and 3-wire SPI pins of the MAX7219 chain driver
interface silife_max7219_chain_if #(
  parameter int ROW_W = 5
);
  logic [ROW_W-1:0] row_select;
  logic [7:0]       cells;
  logic             cs;
  logic             sck;
  logic             mosi;

  modport master (output row_select, cs, sck, mosi, input cells);
  modport slave  (input row_select, cs, sck, mosi, output cells);
endinterface

// File: rtl/silife_spi_shifter.sv
// rtl/silife_spi_shifter.sv - 16-bit MSB-first shifter with SCK divider; CS belongs to the parent
module silife_spi_shifter #(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word,
  output logic        sck,
  output logic        mosi,
  output logic        done
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [15:0]      sr;
  logic [3:0]       bit_cnt;
  logic [DIV_W-1:0] div_cnt;
  logic             active;
  logic             phase_end;

  assign phase_end = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign mosi      = sr[15];
  // done is combinational so the parent leaves SHIFT on the same edge SCK falls for the last time
  assign done      = active && sck && phase_end && (bit_cnt == 4'd15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      div_cnt <= '0;
      active  <= 1'b0;
      sck     <= 1'b0;
    end else if (start && !active) begin
      sr      <= word;
      bit_cnt <= '0;
      div_cnt <= '0;
      active  <= 1'b1;
      sck     <= 1'b0;
    end else if (active) begin
      if (phase_end) begin
        div_cnt <= '0;
        if (!sck) begin
          sck <= 1'b1;
        end else begin
          sck <= 1'b0;
          if (bit_cnt == 4'd15) begin
            active <= 1'b0;
          end else begin
            bit_cnt <= bit_cnt + 4'd1;
            sr      <= {sr[14:0], 1'b0};
          end
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/silife_max7219_chain.sv
// rtl/silife_max7219_chain.sv - daisy-chained MAX7219 life-grid display driver
// Optional mirror/180-degree rotation when SILIFE_MAX7219_MIRROR_EN is defined.
module silife_max7219_chain
  import silife_max7219_pkg::*;
#(
  parameter int NUM_DEVICES = 4,
  parameter int CLK_DIV     = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_enable,
  input  logic       i_frame,
  input  logic [3:0] i_brightness,
`ifdef SILIFE_MAX7219_MIRROR_EN
  input  logic       i_mirror,
`endif
  output logic       o_busy,
  output logic       o_frame_done,
  silife_max7219_chain_if.master bus
);
  localparam int ROW_W = ($clog2(8 * NUM_DEVICES) > 1) ? $clog2(8 * NUM_DEVICES) : 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [3:0] LAST_DEV = 4'(NUM_DEVICES - 1);

  state_t           state, next;
  group_t           group;
  logic [2:0]       init_idx;
  logic [2:0]       digit;
  logic [3:0]       dev;
  logic [DIV_W-1:0] wait_cnt;
  logic [3:0]       bright_val;
  logic [3:0]       bright_sent;
  logic             init_needed;
  logic             cs_q;
  logic             frame_done_q;
  logic [ROW_W-1:0] row_q;
  logic             mirror_q;
  logic [2:0]       row_digit;
  logic [7:0]       data;
  logic [15:0]      word;
  logic             wait_done;
  logic             shift_done;
  logic             continue_seq;
  logic             frame_start;
  logic             sck_w;
  logic             mosi_w;

  function automatic logic [ROW_W-1:0] row_of(input logic [3:0] j, input logic [2:0] d);
    return ROW_W'({j, d});
  endfunction

  assign wait_done = (wait_cnt == DIV_W'(CLK_DIV - 1));
  assign row_digit = mirror_q ? (3'd7 - digit) : digit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next         = state;
    continue_seq = i_enable;
    frame_start  = 1'b0;
    if (group == GRP_INIT && init_idx == 3'd4) continue_seq = 1'b0;
    if (group == GRP_DIGIT && digit == 3'd7)   continue_seq = i_enable && i_frame;
    case (state)
      IDLE: begin
        if (i_enable && (init_needed || i_frame)) begin
          next        = LOAD;
          frame_start = !init_needed;
        end
      end
      LOAD:   if (wait_done) next = FETCH;
      FETCH:  next = SAMPLE;
      SAMPLE: next = SHIFT;
      SHIFT:  if (shift_done) next = (dev == 4'd0) ? LATCH : FETCH;
      LATCH: begin
        if (wait_done) begin
          next        = continue_seq ? LOAD : IDLE;
          // end of a frame rolls straight into the next one without visiting IDLE
          frame_start = continue_seq && (group == GRP_DIGIT) && (digit == 3'd7);
        end
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      group        <= GRP_INIT;
      init_idx     <= '0;
      digit        <= '0;
      dev          <= '0;
      wait_cnt     <= '0;
      bright_val   <= '0;
      bright_sent  <= '0;
      init_needed  <= 1'b1;
      cs_q         <= 1'b1;
      frame_done_q <= 1'b0;
      row_q        <= '0;
    end else begin
      frame_done_q <= 1'b0;
      if (next != state || !(state inside {LOAD, LATCH})) wait_cnt <= '0;
      else                                               wait_cnt <= wait_cnt + 1'b1;
      if (frame_start) begin
        digit      <= '0;
        bright_val <= i_brightness;
        group      <= (i_brightness != bright_sent) ? GRP_BRIGHT : GRP_DIGIT;
      end
      case (state)
        IDLE: begin
          if (next == LOAD && init_needed) begin
            group      <= GRP_INIT;
            init_idx   <= '0;
            bright_val <= i_brightness;
          end
        end
        LOAD: begin
          if (next == FETCH) begin
            dev   <= LAST_DEV;
            row_q <= row_of(LAST_DEV, row_digit);
          end
        end
        SAMPLE: cs_q <= 1'b0;
        SHIFT: begin
          if (shift_done && dev != 4'd0) begin
            dev   <= dev - 4'd1;
            row_q <= row_of(dev - 4'd1, row_digit);
          end
        end
        LATCH: begin
          if (wait_done) begin
            cs_q <= 1'b1;
            case (group)
              GRP_INIT: begin
                if (init_idx == 3'd4) begin
                  init_needed <= 1'b0;
                  bright_sent <= bright_val;
                end else begin
                  init_idx <= init_idx + 3'd1;
                end
              end
              GRP_BRIGHT: begin
                bright_sent <= bright_val;
                group       <= GRP_DIGIT;
                if (!i_enable) init_needed <= 1'b1;
              end
              default: begin
                if (digit == 3'd7)  frame_done_q <= 1'b1;
                else if (i_enable)  digit        <= digit + 3'd1;
                else                init_needed  <= 1'b1;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SILIFE_MAX7219_MIRROR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           mirror_q <= 1'b0;
    else if (frame_start) mirror_q <= i_mirror;
  end
`else
  assign mirror_q = 1'b0;
`endif

  always_comb begin
    word = '0;
    data = mirror_q ? bit_reverse(bus.cells) : bus.cells;
    case (group)
      GRP_INIT: begin
        case (init_idx)
          3'd0:    word = INIT_SHUTDOWN;
          3'd1:    word = INIT_DECODE;
          3'd2:    word = INIT_SCANLIMIT;
          3'd3:    word = INIT_TEST;
          default: word = make_word(REG_INTENSITY, {4'h0, bright_val});
        endcase
      end
      GRP_BRIGHT: word = make_word(REG_INTENSITY, {4'h0, bright_val});
      default:    word = make_word(REG_DIGIT0 + {1'b0, digit}, data);
    endcase
  end

  silife_spi_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .clk   (clk),
    .rst_n (rst_n),
    .start (state == SAMPLE),
    .word  (word),
    .sck   (sck_w),
    .mosi  (mosi_w),
    .done  (shift_done)
  );

  assign bus.cs         = cs_q;
  assign bus.sck        = sck_w;
  assign bus.mosi       = mosi_w;
  assign bus.row_select = row_q;
  assign o_busy         = (state != IDLE);
  assign o_frame_done   = frame_done_q;

endmodule
